// File: rtl/bus_sched_pkg.sv
// rtl/bus_sched_pkg.sv - shared types and helpers for the bus slot scheduler
package bus_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    // Index width that stays at least one bit wide for degenerate counts.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_slot_scheduler_rr_pick.sv
// rtl/bus_slot_scheduler_rr_pick.sv - combinational rotating-priority picker
module rr_pick
    import bus_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [idx_w(NREQ)-1:0]  last,
    output logic                    valid,
    output logic [idx_w(NREQ)-1:0]  idx
);

    localparam int IW = idx_w(NREQ);

    logic          found;
    int            c;
    logic [IW-1:0] ci;

    // Scan starts one past the previous owner so the last winner has lowest priority.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = 0;
        ci    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            c  = (int'(last) + i) % NREQ;
            ci = IW'(c);
            if (!found && req[ci]) begin
                found = 1'b1;
                idx   = ci;
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/bus_slot_scheduler.sv
// rtl/bus_slot_scheduler.sv - weighted round-robin bus tenure scheduler with stall watchdog
module bus_slot_scheduler
    import bus_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int QW   = 4,
    parameter int TOW  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         beat,
    input  logic [NREQ*QW-1:0]      quota,
    input  logic [TOW-1:0]          timeout_cycles,
    output logic [NREQ-1:0]         gnt,
    output logic [idx_w(NREQ)-1:0]  gnt_id,
    output logic                    busy,
    output logic                    timeout_evt
);

    localparam int IW = idx_w(NREQ);

    sched_state_t  state, state_n;
    logic [IW-1:0] sel;
    logic [IW-1:0] last;
    logic [QW-1:0] qcnt;
    logic [TOW-1:0] tcnt;
    logic [TOW-1:0] to_lim;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [QW-1:0] qsel;
    logic          cur_req, cur_beat;
    logic          rel_a, rel_b, rel_c, rel;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign qsel     = quota[pick_idx*QW +: QW];
    assign cur_req  = req[sel];
    assign cur_beat = beat[sel];

    assign rel_a = !cur_req;
    assign rel_b = cur_beat && (qcnt == QW'(1));
    assign rel_c = (to_lim != '0) && !cur_beat && (tcnt == to_lim - TOW'(1));
    assign rel   = (state == GRANT) && (rel_a || rel_b || rel_c);

    assign gnt_id = sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pick_valid) state_n = GRANT;
            GRANT:   if (rel)        state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel         <= '0;
            last        <= IW'(NREQ - 1);
            qcnt        <= '0;
            tcnt        <= '0;
            to_lim      <= '0;
            gnt         <= '0;
            busy        <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        sel    <= pick_idx;
                        qcnt   <= (qsel == '0) ? QW'(1) : qsel;
                        tcnt   <= '0;
                        to_lim <= timeout_cycles;
                        gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        busy   <= 1'b1;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        last <= sel;
                        gnt  <= '0;
                        busy <= 1'b0;
                        // A dropped request wins over the watchdog as the reported cause.
                        timeout_evt <= rel_c && !rel_a;
                    end else if (cur_beat) begin
                        qcnt <= qcnt - QW'(1);
                        tcnt <= '0;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + TOW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
